lcd_seq_ctrl: RTL and testbench

- Sequencer for the character-LCD path (HD44780-style parallel bus, 8-bit mode, write-only).
- Runs the power-up delay and the four-command init. Then refreshes the display forever: line-1 address, 16 characters, line-2 address, 16 characters, repeat.
- Characters are fetched from a separate character-source block over a REQ/ACK handshake. This block owns all LCD bus timing (RS/RW/E/DATA).

---
 rtl/lcd_pkg.sv | 45 ++++
 rtl/lcd_seq_ctrl_if.sv | 35 +++
 rtl/lcd_write_phy.sv | 104 ++++++++++
 rtl/lcd_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lcd_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the character-LCD sequencer
//
// Purpose: sequencer state encoding, write-phy phase encoding, HD44780 command
// bytes, the four-entry init command ROM and a small sizing helper.
// Ports: none (package).

package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_INIT,
    ST_ADDR1,
    ST_FETCH,
    ST_WCHAR,
    ST_ADDR2
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_EHIGH,
    PH_GAP
  } phy_phase_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] ADDR_LINE1   = 8'h80;
  localparam logic [7:0] ADDR_LINE2   = 8'hC0;

  // Init ROM, entry [0] is sent first.
  localparam logic [3:0][7:0] INIT_ROM = {CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON, CMD_FUNC_SET};

  localparam logic [1:0] INIT_LAST_IDX = 2'd3;
  // The clear command needs the long settle time.
  localparam logic [1:0] CLEAR_IDX     = 2'd2;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// rtl/lcd_seq_ctrl_if.sv - character-source handshake and LCD bus bundle
//
// Purpose: groups the REQ/ACK character fetch and the HD44780 write bus.
// Signals:
//   CHAR_REQ/CHAR_LINE/CHAR_POS  sequencer -> source request and address
//   CHAR_ACK/CHAR_DATA           source -> sequencer reply
//   LCD_E/LCD_RS/LCD_RW/LCD_DATA sequencer -> display bus
// Modports: master = sequencer side, slave = source/display side.

interface lcd_seq_ctrl_if;

  logic       CHAR_REQ;
  logic       CHAR_LINE;
  logic [3:0] CHAR_POS;
  logic       CHAR_ACK;
  logic [7:0] CHAR_DATA;

  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport master (
    output CHAR_REQ, CHAR_LINE, CHAR_POS,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA,
    input  CHAR_ACK, CHAR_DATA
  );

  modport slave (
    input  CHAR_REQ, CHAR_LINE, CHAR_POS,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA,
    output CHAR_ACK, CHAR_DATA
  );

endinterface

// File: rtl/lcd_write_phy.sv
// rtl/lcd_write_phy.sv - one HD44780 write cycle: setup, E high, settle gap
//
// Purpose: on start_i (taken on an enable tick) latches RS/byte and runs
// 1 setup tick, E_TICKS ticks of E=1, then GAP_TICKS (or CLEAR_GAP_TICKS when
// long_gap_i) ticks of E=0. RS/DATA stay put for the whole cycle and beyond.
// Ports:
//   clk_i, rst_i (sync active-high), enable_i (tick)
//   start_i, rs_i, byte_i, long_gap_i  write request
//   lcd_e_o, lcd_rs_o, lcd_data_o      bus drive
//   busy_o                             a cycle is in progress
//   done_o                             last gap tick, combinational; a new
//                                      start on this same edge runs back to back

module lcd_write_phy
  import lcd_pkg::*;
#(
  parameter int E_TICKS         = 2,
  parameter int GAP_TICKS       = 4,
  parameter int CLEAR_GAP_TICKS = 40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  input  logic       long_gap_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(max_of3(E_TICKS, GAP_TICKS, CLEAR_GAP_TICKS) + 1);

  phy_phase_e  phase_q;
  logic [CW-1:0] cnt_q;
  logic        e_q;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        long_q;
  logic [CW-1:0] gap_len;

  assign gap_len = long_q ? CW'(CLEAR_GAP_TICKS) : CW'(GAP_TICKS);

  // cnt_q counts 1..N inside the E-high and gap phases, so the terminal
  // compare is against the tick count itself.
  assign done_o = enable_i && (phase_q == PH_GAP) && (cnt_q == gap_len);
  assign busy_o = (phase_q != PH_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else if (enable_i) begin
      if (start_i) begin
        phase_q <= PH_SETUP;
        cnt_q   <= '0;
        e_q     <= 1'b0;
        rs_q    <= rs_i;
        data_q  <= byte_i;
        long_q  <= long_gap_i;
      end else begin
        case (phase_q)
          PH_SETUP: begin
            phase_q <= PH_EHIGH;
            e_q     <= 1'b1;
            cnt_q   <= CW'(1);
          end
          PH_EHIGH: begin
            if (cnt_q == CW'(E_TICKS)) begin
              phase_q <= PH_GAP;
              e_q     <= 1'b0;
              cnt_q   <= CW'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PH_GAP: begin
            if (cnt_q == gap_len) begin
              phase_q <= PH_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            phase_q <= PH_IDLE;
          end
        endcase
      end
    end
  end

  assign lcd_e_o    = e_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - character-LCD power-up, init and endless refresh sequencer
//
// Purpose: waits POWERUP_TICKS, sends the four init commands, then refreshes
// line 1 and line 2 (address + CHARS characters each) forever, fetching each
// character over the REQ/ACK handshake.
// Ports:
//   CLK, RESETN (sync, active-high), ENABLE (timebase tick)
//   bus        master side of lcd_seq_ctrl_if (character fetch + LCD bus)
//   INIT_DONE  sticky once the init commands have been written

module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int POWERUP_TICKS   = 70,
  parameter int E_TICKS         = 2,
  parameter int GAP_TICKS       = 4,
  parameter int CLEAR_GAP_TICKS = 40,
  parameter int CHARS           = 16
) (
  input  logic           CLK,
  input  logic           RESETN,
  input  logic           ENABLE,
  lcd_seq_ctrl_if.master bus,
  output logic           INIT_DONE
);

  localparam int PW = $clog2(POWERUP_TICKS + 1);

  lcd_state_e    state_q, state_d;
  logic [PW-1:0] pwr_cnt_q;
  logic [1:0]    cmd_idx_q;
  logic          line_q;
  logic [3:0]    pos_q;
  logic [7:0]    char_q;
  logic          init_done_q;

  logic          phy_start;
  logic          phy_rs;
  logic [7:0]    phy_byte;
  logic          phy_long;
  logic          phy_busy;
  logic          phy_done;
  logic          char_req;

  logic          pwr_done;
  logic          last_pos;
  logic [1:0]    cmd_idx_next;

  assign pwr_done     = (pwr_cnt_q == PW'(POWERUP_TICKS));
  assign last_pos     = (pos_q == 4'(CHARS - 1));
  assign cmd_idx_next = cmd_idx_q + 2'd1;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state_q <= ST_POWERUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Only FETCH reacts on non-tick edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_POWERUP: if (ENABLE && pwr_done) state_d = ST_INIT;
      ST_INIT:    if (phy_done && (cmd_idx_q == INIT_LAST_IDX)) state_d = ST_ADDR1;
      ST_ADDR1:   if (phy_done) state_d = ST_FETCH;
      ST_ADDR2:   if (phy_done) state_d = ST_FETCH;
      ST_FETCH:   if (bus.CHAR_ACK) state_d = ST_WCHAR;
      ST_WCHAR: begin
        if (phy_done) begin
          if (!last_pos)   state_d = ST_FETCH;
          else if (line_q) state_d = ST_ADDR1;
          else             state_d = ST_ADDR2;
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  // Output logic: every write is launched on the same edge that enters its
  // state, so consecutive writes run back to back with no idle tick, except
  // the character write which starts on the first tick after the ACK edge.
  always_comb begin
    phy_start = 1'b0;
    phy_rs    = 1'b0;
    phy_byte  = 8'h00;
    phy_long  = 1'b0;
    char_req  = 1'b0;
    case (state_q)
      ST_POWERUP: begin
        if (ENABLE && pwr_done) begin
          phy_start = 1'b1;
          phy_byte  = INIT_ROM[0];
        end
      end
      ST_INIT: begin
        if (phy_done) begin
          phy_start = 1'b1;
          if (cmd_idx_q == INIT_LAST_IDX) begin
            phy_byte = ADDR_LINE1;
          end else begin
            phy_byte = INIT_ROM[cmd_idx_next];
            phy_long = (cmd_idx_next == CLEAR_IDX);
          end
        end
      end
      ST_FETCH: begin
        char_req = 1'b1;
      end
      ST_WCHAR: begin
        if (ENABLE && !phy_busy) begin
          phy_start = 1'b1;
          phy_rs    = 1'b1;
          phy_byte  = char_q;
        end else if (phy_done && last_pos) begin
          phy_start = 1'b1;
          phy_byte  = line_q ? ADDR_LINE1 : ADDR_LINE2;
        end
      end
      default: begin
      end
    endcase
  end

  // Counters, latched character and init flag.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      pwr_cnt_q   <= '0;
      cmd_idx_q   <= 2'd0;
      line_q      <= 1'b0;
      pos_q       <= 4'd0;
      char_q      <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_POWERUP: begin
          if (ENABLE && !pwr_done) pwr_cnt_q <= pwr_cnt_q + PW'(1);
        end
        ST_INIT: begin
          if (phy_done) begin
            cmd_idx_q <= cmd_idx_next;
            if (cmd_idx_q == INIT_LAST_IDX) begin
              init_done_q <= 1'b1;
              line_q      <= 1'b0;
              pos_q       <= 4'd0;
            end
          end
        end
        ST_FETCH: begin
          if (bus.CHAR_ACK) char_q <= bus.CHAR_DATA;
        end
        ST_WCHAR: begin
          if (phy_done) begin
            if (!last_pos) begin
              pos_q <= pos_q + 4'd1;
            end else begin
              line_q <= ~line_q;
              pos_q  <= 4'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  lcd_write_phy #(
    .E_TICKS         (E_TICKS),
    .GAP_TICKS       (GAP_TICKS),
    .CLEAR_GAP_TICKS (CLEAR_GAP_TICKS)
  ) u_phy (
    .clk_i      (CLK),
    .rst_i      (RESETN),
    .enable_i   (ENABLE),
    .start_i    (phy_start),
    .rs_i       (phy_rs),
    .byte_i     (phy_byte),
    .long_gap_i (phy_long),
    .lcd_e_o    (bus.LCD_E),
    .lcd_rs_o   (bus.LCD_RS),
    .lcd_data_o (bus.LCD_DATA),
    .busy_o     (phy_busy),
    .done_o     (phy_done)
  );

  assign bus.LCD_RW    = 1'b0;
  assign bus.CHAR_REQ  = char_req;
  assign bus.CHAR_LINE = line_q;
  assign bus.CHAR_POS  = pos_q;
  assign INIT_DONE     = init_done_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb/tb_lcd_seq_ctrl.sv - self-checking bench for lcd_seq_ctrl

module tb_lcd_seq_ctrl;

  logic clk;
  logic RESETN;
  logic ENABLE;
  logic init_done;

  lcd_seq_ctrl_if bus();

  lcd_seq_ctrl #(
    .POWERUP_TICKS   (70),
    .E_TICKS         (2),
    .GAP_TICKS       (4),
    .CLEAR_GAP_TICKS (40),
    .CHARS           (16)
  ) dut (
    .CLK       (clk),
    .RESETN    (RESETN),
    .ENABLE    (ENABLE),
    .bus       (bus),
    .INIT_DONE (init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [2][16];
  logic [8:0] exp_q [$];
  int   en_period   = 1;
  bit   comb_mode   = 1'b1;
  bit   stall_hold  = 1'b0;
  bit   mon_on      = 1'b0;
  bit   en_last_edge;
  int   k_fetch     = 0;
  logic ack_drv     = 1'b0;
  logic [7:0] data_drv = 8'h00;

  assign bus.CHAR_ACK  = comb_mode ? bus.CHAR_REQ : ack_drv;
  assign bus.CHAR_DATA = comb_mode ? mem[bus.CHAR_LINE][bus.CHAR_POS] : data_drv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Timebase: ENABLE high on one CLK of every en_period.
  initial begin
    int div;
    div = 0;
    ENABLE = 1'b0;
    forever begin
      @(negedge clk);
      ENABLE = (div == 0);
      div = (div + 1 >= en_period) ? 0 : div + 1;
    end
  end

  always @(posedge clk) en_last_edge = ENABLE;

  // Character source with random ACK latency, junk data outside the ACK
  // cycle and occasional stray ACKs while no request is pending.
  initial begin
    int wait_n;
    wait_n = 0;
    forever begin
      @(negedge clk);
      if (ack_drv) begin
        ack_drv  = 1'b0;
        data_drv = 8'($urandom);
      end else if (!comb_mode && bus.CHAR_REQ) begin
        if (stall_hold && bus.CHAR_LINE == 1'b1 && bus.CHAR_POS == 4'd5) begin
          wait_n = 0;
        end else if (wait_n > 0) begin
          wait_n--;
        end else begin
          check_eq("req_line", 32'(bus.CHAR_LINE), 32'((k_fetch / 16) % 2));
          check_eq("req_pos", 32'(bus.CHAR_POS), 32'(k_fetch % 16));
          ack_drv  = 1'b1;
          data_drv = mem[bus.CHAR_LINE][bus.CHAR_POS];
          k_fetch++;
          wait_n = $urandom_range(0, 4);
        end
      end else if (!comb_mode && !bus.CHAR_REQ && $urandom_range(0, 3) == 0) begin
        ack_drv  = 1'b1;
        data_drv = 8'($urandom);
      end
    end
  end

  // Bus monitor: every E pulse is matched against the expected write list,
  // RS/DATA must hold while E is high, E-high lasts E_TICKS ticks, and
  // nothing on the bus moves across a CLK edge without ENABLE.
  initial begin
    logic prev_e;
    int   e_len;
    logic [8:0] cur;
    logic [10:0] prev_bus;
    logic [10:0] now_bus;
    logic [8:0] expw;
    prev_e = 1'b0;
    e_len  = 0;
    cur    = '0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      now_bus = {bus.LCD_E, bus.LCD_RS, bus.LCD_DATA, init_done};
      if (mon_on) begin
        if (!en_last_edge) check_eq("hold_no_tick", 32'(now_bus), 32'(prev_bus));
        if (bus.LCD_E && !prev_e) begin
          e_len = 1;
          cur = {bus.LCD_RS, bus.LCD_DATA};
          check_eq("rw_low", 32'(bus.LCD_RW), 32'd0);
          if (exp_q.size() > 0) begin
            expw = exp_q.pop_front();
            check_eq("write_byte", 32'(cur), 32'(expw));
          end
        end else if (bus.LCD_E) begin
          e_len++;
          check_eq("rs_data_stable", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'(cur));
        end else if (prev_e) begin
          check_eq("e_high_clks", 32'(e_len), 32'(2 * en_period));
        end
      end
      prev_e   = bus.LCD_E;
      prev_bus = now_bus;
    end
  end

  // Expected write list: init commands, then alternating line address plus
  // the 16 characters of that line, ending with the next line address.
  task automatic build_exp(input int nlines);
    logic [7:0] a;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    for (int l = 0; l < nlines; l++) begin
      a = (l % 2 == 0) ? 8'h80 : 8'hC0;
      exp_q.push_back({1'b0, a});
      for (int p = 0; p < 16; p++) exp_q.push_back({1'b1, mem[l % 2][p]});
    end
    a = (nlines % 2 == 0) ? 8'h80 : 8'hC0;
    exp_q.push_back({1'b0, a});
  endtask

  task automatic do_reset(input int period, input bit comb, input bit fixed41,
                          input bit put5a, input int nlines);
    @(negedge clk);
    mon_on = 1'b0;
    RESETN = 1'b1;
    en_period = period;
    comb_mode = comb;
    stall_hold = 1'b0;
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 16; p++)
        mem[l][p] = fixed41 ? 8'h41 : 8'($urandom);
    if (put5a) mem[1][5] = 8'h5A;
    k_fetch = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_e", 32'(bus.LCD_E), 32'd0);
    check_eq("rst_rs", 32'(bus.LCD_RS), 32'd0);
    check_eq("rst_rw", 32'(bus.LCD_RW), 32'd0);
    check_eq("rst_data", 32'(bus.LCD_DATA), 32'h00);
    check_eq("rst_req", 32'(bus.CHAR_REQ), 32'd0);
    check_eq("rst_line", 32'(bus.CHAR_LINE), 32'd0);
    check_eq("rst_pos", 32'(bus.CHAR_POS), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    build_exp(nlines);
    RESETN = 1'b0;
    mon_on = 1'b1;
  endtask

  // Tick-exact power-up/init timeline, ENABLE every CLK: a write whose setup
  // tick is s has E=1 at s+1 and s+2. Setup ticks follow from 70 idle ticks,
  // 7-tick writes and a 43-tick clear.
  task automatic run_tick_checks();
    int starts [5];
    logic [7:0] bytes [5];
    bit exp_e;
    starts = '{70, 77, 84, 127, 134};
    bytes  = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    for (int t = 0; t <= 140; t++) begin
      @(posedge clk);
      #1;
      exp_e = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (t == starts[i] + 1 || t == starts[i] + 2) exp_e = 1'b1;
        if (t == starts[i]) begin
          check_eq("setup_data", 32'(bus.LCD_DATA), 32'(bytes[i]));
          check_eq("setup_rs", 32'(bus.LCD_RS), 32'd0);
        end
      end
      check_eq("tick_e", 32'(bus.LCD_E), 32'(exp_e));
      check_eq("tick_init_done", 32'(init_done), 32'(t >= 134));
      if (t == 69) check_eq("idle_data", 32'(bus.LCD_DATA), 32'h00);
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    RESETN = 1'b1;

    // Tick-exact timeline with a combinational source returning 8'h41.
    do_reset(1, 1'b1, 1'b1, 1'b0, 2);
    run_tick_checks();
    wait_drain(2000);

    // Full refresh, random text, random ACK latency.
    do_reset(1, 1'b0, 1'b0, 1'b0, 3);
    wait_drain(5000);

    // Slow timebase: one tick every 3 CLKs.
    do_reset(3, 1'b0, 1'b0, 1'b0, 2);
    wait_drain(10000);

    // Source stalls at line 1 position 5, then answers 8'h5A.
    do_reset(1, 1'b0, 1'b0, 1'b1, 2);
    stall_hold = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (bus.CHAR_REQ && bus.CHAR_LINE == 1'b1 && bus.CHAR_POS == 4'd5) found = 1'b1;
    end
    check_eq("stall_reached", 32'(found), 32'd1);
    repeat (50) begin
      @(negedge clk);
      check_eq("stall_req", 32'(bus.CHAR_REQ), 32'd1);
      check_eq("stall_e", 32'(bus.LCD_E), 32'd0);
    end
    check_eq("stall_line", 32'(bus.CHAR_LINE), 32'd1);
    check_eq("stall_pos", 32'(bus.CHAR_POS), 32'd5);
    stall_hold = 1'b0;
    wait_drain(2000);

    // Reset in the middle of a character write.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.LCD_E && bus.LCD_RS) found = 1'b1;
    end
    check_eq("midwrite_found", 32'(found), 32'd1);
    mon_on = 1'b0;
    RESETN = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_e", 32'(bus.LCD_E), 32'd0);
    check_eq("mid_rst_data", 32'(bus.LCD_DATA), 32'h00);
    check_eq("mid_rst_rs", 32'(bus.LCD_RS), 32'd0);
    check_eq("mid_rst_req", 32'(bus.CHAR_REQ), 32'd0);
    check_eq("mid_rst_init_done", 32'(init_done), 32'd0);
    do_reset(1, 1'b1, 1'b1, 1'b0, 2);
    run_tick_checks();
    wait_drain(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
